// File: rtl/gas_detector_pkg.sv
// gas_detector_pkg: default gas signatures, their lengths and dout bit positions
package gas_detector_pkg;
    localparam int CH4_LEN = 5;
    localparam int CO_LEN  = 4;
    localparam int H2_LEN  = 4;
    localparam logic [CH4_LEN-1:0] CH4_PAT_DEF = 5'b10101;
    localparam logic [CO_LEN-1:0]  CO_PAT_DEF  = 4'b1001;
    localparam logic [H2_LEN-1:0]  H2_PAT_DEF  = 4'b1111;
    localparam int IDX_CH4 = 0;
    localparam int IDX_CO  = 1;
    localparam int IDX_H2  = 2;
endpackage

// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: overlapping MSB-first serial pattern matcher with registered hit
module serial_pattern_detector #(
    parameter int LEN = 4,
    parameter logic [LEN-1:0] PAT = '1
) (
    input  logic clk,
    input  logic arst,
    input  logic din,
    output logic hit
);
    localparam int SW = $clog2(LEN + 1);
    logic [SW-1:0] st;
    logic [SW-1:0] nxt;
    // State is the matched prefix length; the received tail is prefix[0..st-1] then b,
    // so the next state is the longest prefix that is a suffix of that tail.
    function automatic logic [SW-1:0] next_state(input logic [SW-1:0] s, input logic b);
        int cur;
        int best;
        int idx;
        logic ok;
        logic c;
        cur = int'(s);
        best = 0;
        for (int k = 1; k <= LEN; k++) begin
            ok = (k <= cur + 1);
            for (int j = 0; j < LEN; j++) begin
                if (ok && j < k) begin
                    idx = cur + 1 - k + j;
                    c = (idx == cur) ? b : PAT[LEN-1-idx];
                    ok = (c == PAT[LEN-1-j]);
                end
            end
            if (ok) best = k;
        end
        return SW'(best);
    endfunction
    always_comb nxt = next_state(st, din);
    always_ff @(posedge clk) begin
        if (arst) begin
            st  <= '0;
            hit <= 1'b0;
        end else begin
            st  <= nxt;
            hit <= (nxt == SW'(LEN));
        end
    end
endmodule

// File: rtl/gas_detector_sensor.sv
// gas_detector_sensor: three parallel serial signature detectors driving registered gas flags
module gas_detector_sensor
    import gas_detector_pkg::*;
#(
    parameter logic [CH4_LEN-1:0] METHANE_PAT = CH4_PAT_DEF,
    parameter logic [CO_LEN-1:0]  CO_PAT      = CO_PAT_DEF,
    parameter logic [H2_LEN-1:0]  H2_PAT      = H2_PAT_DEF
) (
    input  logic       clk,
    input  logic       arst,
    input  logic       din,
    output logic [2:0] dout
);
    serial_pattern_detector #(.LEN(CH4_LEN), .PAT(METHANE_PAT)) u_ch4 (
        .clk(clk), .arst(arst), .din(din), .hit(dout[IDX_CH4])
    );
    serial_pattern_detector #(.LEN(CO_LEN), .PAT(CO_PAT)) u_co (
        .clk(clk), .arst(arst), .din(din), .hit(dout[IDX_CO])
    );
    serial_pattern_detector #(.LEN(H2_LEN), .PAT(H2_PAT)) u_h2 (
        .clk(clk), .arst(arst), .din(din), .hit(dout[IDX_H2])
    );
endmodule

// File: tb/tb_gas_detector_sensor.sv
// tb_gas_detector_sensor: directed-vector self-checking bench for gas_detector_sensor
module tb_gas_detector_sensor;
    logic       clk = 1'b0;
    logic       arst = 1'b0;
    logic       din = 1'b0;
    logic [2:0] dout;
    int checks = 0;
    int errors = 0;

    gas_detector_sensor dut (.clk(clk), .arst(arst), .din(din), .dout(dout));

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic b);
        @(negedge clk);
        arst = r;
        din = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0);
        checks++;
        if (dout !== 3'b000) begin
            errors++;
            $display("FAIL reset_edge: got %b expected 000", dout);
        end
        step(1'b0, 1'b0);
        checks++;
        if (dout !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 000", dout);
        end
    endtask

    task automatic test_main_stream();
        logic [13:0] seq = 14'b10101001001111;
        logic [2:0] exp [14] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b000,
                                 3'b010, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000, 3'b100};
        for (int i = 0; i < 14; i++) begin
            step(1'b0, seq[13-i]);
            checks++;
            if (dout !== exp[i]) begin
                errors++;
                $display("FAIL main_stream bit %0d: got %b expected %b", i + 1, dout, exp[i]);
            end
        end
    endtask

    task automatic test_methane_overlap();
        logic [6:0] seq = 7'b1010101;
        logic [2:0] exp [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b000, 3'b001};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, seq[6-i]);
            checks++;
            if (dout !== exp[i]) begin
                errors++;
                $display("FAIL methane_overlap bit %0d: got %b expected %b", i + 1, dout, exp[i]);
            end
        end
    endtask

    task automatic test_h2_run();
        logic [2:0] exp [6] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b100};
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1);
            checks++;
            if (dout !== exp[i]) begin
                errors++;
                $display("FAIL h2_run bit %0d: got %b expected %b", i + 1, dout, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] seq = 4'b1010;
        for (int i = 0; i < 4; i++) step(1'b0, seq[3-i]);
        step(1'b1, 1'b1);
        checks++;
        if (dout !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_edge: got %b expected 000", dout);
        end
        step(1'b0, 1'b1);
        checks++;
        if (dout !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_after: got %b expected 000", dout);
        end
    endtask

    task automatic test_fallback();
        logic [6:0] seq = 7'b1011001;
        logic [2:0] exp [7] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, seq[6-i]);
            checks++;
            if (dout !== exp[i]) begin
                errors++;
                $display("FAIL fallback bit %0d: got %b expected %b", i + 1, dout, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] seq = 10'b1001001001;
        logic [2:0] exp [10] = '{3'b000, 3'b000, 3'b000, 3'b010, 3'b000,
                                 3'b000, 3'b010, 3'b000, 3'b000, 3'b010};
        for (int i = 0; i < 10; i++) begin
            step(1'b0, seq[9-i]);
            checks++;
            if (dout !== exp[i]) begin
                errors++;
                $display("FAIL co_back_to_back bit %0d: got %b expected %b", i + 1, dout, exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_main_stream();
        test_reset();
        test_methane_overlap();
        test_reset();
        test_h2_run();
        test_reset();
        test_reset_mid();
        test_reset();
        test_fallback();
        test_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/gas_detector_sensor.md
GAS_DETECTOR_SENSOR -- requirements
Module: gas_detector_sensor

Interface
REQ-001 Parameter METHANE_PAT, default 5'b10101, methane signature, first-received bit is the MSB.
REQ-002 Parameter CO_PAT, default 4'b1001, carbon-monoxide signature, MSB first.
REQ-003 Parameter H2_PAT, default 4'b1111, hydrogen signature, MSB first.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port arst, input, 1 bit: reset, synchronous and active-high (the name is historical; behaviour is synchronous).
REQ-006 Port din, input, 1 bit: serial sensor bit stream, one bit sampled per rising clk edge.
REQ-007 Port dout, output, 3 bits: gas-detect flags; dout[0] is methane, dout[1] is CO, dout[2] is H2.

Function
REQ-008 The block SHALL sample din on every rising clk edge where arst=0.
REQ-009 The block SHALL run three independent serial pattern detectors, one per signature, all fed by the same sampled bit.
REQ-010 Each detector SHALL be a Moore FSM whose state equals the length of the longest signature prefix matching the most recent sampled bits (KMP-style fallback on mismatch).
REQ-011 The methane FSM SHALL have states S0..S5 and the CO and H2 FSMs SHALL have states S0..S4, where S_N means a full match.
REQ-012 On mismatch, an FSM SHALL transition to the longest proper prefix that is also a suffix of the received bits, not unconditionally to S0.
REQ-013 Overlapping matches SHALL be detected:
- 10101 followed by 01 gives a second methane hit.
- 1001 followed by 001 gives a second CO hit.
- Each further 1 after 1111 gives another H2 hit.
REQ-014 dout[i] SHALL be 1 for exactly one clock period immediately following the edge that sampled the final bit of a match, and 0 otherwise.
REQ-015 Back-to-back overlapping matches SHALL keep dout[i] high on consecutive cycles.
REQ-016 dout bits SHALL be independent; if multiple signatures complete on the same edge, all corresponding bits SHALL be set together (not reachable with default patterns).
REQ-017 dout SHALL be driven directly from registered state with no combinational path from din.
REQ-018 Latency SHALL be zero extra cycles: the flag is valid during the cycle after the last-bit edge.

Reset
REQ-019 While arst=1 at a rising edge, all FSMs SHALL go to S0 and dout SHALL be 3'b000 after that edge.
REQ-020 din SHALL be ignored while arst=1.
REQ-021 Reset asserted mid-pattern SHALL discard all partial matches; detection restarts from the first bit sampled after arst deasserts.
REQ-022 dout SHALL be unknown-free (000) from the first reset edge onward.

Structure
REQ-023 A shared package gas_detector_pkg SHALL hold:
- default signature constants and their lengths;
- the dout bit index constants (IDX_CH4=0, IDX_CO=1, IDX_H2=2).
REQ-024 A generic sub-module serial_pattern_detector, parameterised by pattern and length, SHALL be instantiated three times.
REQ-025 serial_pattern_detector SHALL have ports clk, arst, din and hit.

Verification
REQ-026 Reset sequence: arst=1 for one edge with din=0, then arst=0 and din=0 for one edge -> dout=000 throughout.
REQ-027 Main stream: after REQ-026, feed 1,0,1,0,1,0,0,1,0,0,1,1,1,1 (one bit per edge). Required response:
- dout=001 only after bit 5;
- dout=010 after bit 8;
- dout=010 after bit 11;
- dout=100 after bit 14;
- dout=000 after every other bit.
REQ-028 Methane overlap: feed 1,0,1,0,1,0,1 -> dout=001 after bits 5 and 7, 000 after bit 6.
REQ-029 H2 run: feed 1,1,1,1,1,1 -> dout=100 after bits 4, 5 and 6 (held high for 3 consecutive cycles).
REQ-030 Reset mid-operation: feed 1,0,1,0, assert arst for one edge, then feed 1 -> dout stays 000 (partial match discarded).
REQ-031 Fallback: feed 1,0,1,1,0,0,1 -> dout=010 after bit 7, with no methane flag at any point.
